// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Purpose  : Shared frame-controller types and constants: FSM state encoding,
//            default sync marker, statistics counter width, saturating add.
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

  // Frame controller states, explicitly 3 bits wide
  typedef enum logic [2:0] {
    HUNT = 3'd0,
    LEN  = 3'd1,
    PAY  = 3'd2,
    CHK  = 3'd3,
    HOLD = 3'd4
  } state_t;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
  localparam int         CNT_W         = 8;

  // Increment that sticks at all-ones instead of wrapping
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_frame_buf.sv
`default_nettype none
// ============================================================================
// Module   : uart_frame_buf
// Purpose  : 2**AW x 8 payload RAM, synchronous write, registered read.
// Revision : 1.0 - initial release
// ============================================================================
module uart_frame_buf
  import uart_pkg::*;
#(
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] r_mem [2**AW];

  // Storage array; no reset so it maps onto plain RAM
  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  // Registered read port, cleared by reset so rd_data starts at zero
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata <= 8'd0;
    end else begin
      rdata <= r_mem[raddr];
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_rx_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_frame_ctrl
// Purpose  : Assembles SYNC/LEN/payload/CHK frames from the UART receiver,
//            buffers good payloads for the host, drops and counts bad frames.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_frame_ctrl
  import uart_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE     = SYNC_BYTE_DEF,
  parameter int         MAX_LEN       = 16,
  parameter int         AW            = 4,
  parameter int         TIMEOUT_TICKS = 4096
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          s_tick,
  input  logic          rx_done_tick,
  input  logic          rx_parity_err,
  input  logic [7:0]    din,
  input  logic          frame_ack,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data,
  output logic          frame_valid,
  output logic [4:0]    frame_len,
  output logic          overrun,
  output logic [7:0]    err_cnt,
  output logic [7:0]    drop_cnt,
  output logic          busy
);

  localparam int              c_TW       = $clog2(TIMEOUT_TICKS + 1);
  localparam int              c_CW       = (AW + 1 > 5) ? AW + 1 : 5;
  localparam logic [7:0]      c_MAX_LEN  = 8'(MAX_LEN);
  localparam logic [c_TW-1:0] c_TMO_LAST = c_TW'(TIMEOUT_TICKS - 1);

  state_t           r_state, w_next;
  logic             r_perr;
  logic [4:0]       r_len;
  logic [7:0]       r_xor;
  logic [AW:0]      r_idx;
  logic [c_TW-1:0]  r_tmo;
  logic [CNT_W-1:0] r_err, r_drop;
  logic             r_overrun;

  logic             w_bad, w_in_frame, w_timeout, w_last;
  logic             w_drop, w_latch, w_wr, w_set_ovr, w_clr_ovr;
  logic [AW:0]      w_idx_inc;

  // A byte is bad if a parity pulse was seen since the previous strobe or now
  assign w_bad      = r_perr | rx_parity_err;
  assign w_in_frame = (r_state == LEN) || (r_state == PAY) || (r_state == CHK);
  // Terminal tick aborts only when no byte lands in the same cycle
  assign w_timeout  = w_in_frame && s_tick && !rx_done_tick && (r_tmo == c_TMO_LAST);
  assign w_idx_inc  = r_idx + 1'b1;
  assign w_last     = (c_CW'(w_idx_inc) == c_CW'(r_len));

  assign frame_valid = (r_state == HOLD);
  assign frame_len   = frame_valid ? r_len : 5'd0;
  assign busy        = (r_state != HUNT);
  assign overrun     = r_overrun;
  assign err_cnt     = r_err;
  assign drop_cnt    = r_drop;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= HUNT;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode and datapath control strobes
  always_comb begin
    w_next    = r_state;
    w_drop    = 1'b0;
    w_latch   = 1'b0;
    w_wr      = 1'b0;
    w_set_ovr = 1'b0;
    w_clr_ovr = 1'b0;
    case (r_state)
      HUNT: begin
        if (rx_done_tick && !w_bad && (din == SYNC_BYTE)) begin
          w_next = LEN;
        end
      end
      LEN: begin
        if (rx_done_tick) begin
          if (w_bad || (din == 8'd0) || (din > c_MAX_LEN)) begin
            w_drop = 1'b1;
            w_next = HUNT;
          end else begin
            w_latch = 1'b1;
            w_next  = PAY;
          end
        end else if (w_timeout) begin
          w_drop = 1'b1;
          w_next = HUNT;
        end
      end
      PAY: begin
        if (rx_done_tick) begin
          if (w_bad) begin
            w_drop = 1'b1;
            w_next = HUNT;
          end else begin
            w_wr = 1'b1;
            if (w_last) begin
              w_next = CHK;
            end
          end
        end else if (w_timeout) begin
          w_drop = 1'b1;
          w_next = HUNT;
        end
      end
      CHK: begin
        if (rx_done_tick) begin
          if (!w_bad && (din == r_xor)) begin
            w_next = HOLD;
          end else begin
            w_drop = 1'b1;
            w_next = HUNT;
          end
        end else if (w_timeout) begin
          w_drop = 1'b1;
          w_next = HUNT;
        end
      end
      HOLD: begin
        // Acknowledge takes priority over a simultaneous stray byte
        if (frame_ack) begin
          w_clr_ovr = 1'b1;
          w_next    = HUNT;
        end else if (rx_done_tick) begin
          w_set_ovr = 1'b1;
        end
      end
      default: w_next = HUNT;
    endcase
  end

  // Sticky parity flag, consumed by the next byte strobe
  always_ff @(posedge clk) begin
    if (reset) begin
      r_perr <= 1'b0;
    end else if (rx_done_tick) begin
      r_perr <= 1'b0;
    end else if (rx_parity_err) begin
      r_perr <= 1'b1;
    end
  end

  // Frame length, running checksum and payload write index
  always_ff @(posedge clk) begin
    if (reset) begin
      r_len <= 5'd0;
      r_xor <= 8'd0;
      r_idx <= '0;
    end else if (w_latch) begin
      r_len <= din[4:0];
      r_xor <= din;
      r_idx <= '0;
    end else if (w_wr) begin
      r_xor <= r_xor ^ din;
      r_idx <= w_idx_inc;
    end
  end

  // Inter-byte timeout: counts s_tick while mid-frame, cleared by bytes and state changes
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tmo <= '0;
    end else if (!w_in_frame || rx_done_tick || (w_next != r_state)) begin
      r_tmo <= '0;
    end else if (s_tick) begin
      r_tmo <= r_tmo + 1'b1;
    end
  end

  // Saturating parity-error and dropped-frame statistics
  always_ff @(posedge clk) begin
    if (reset) begin
      r_err  <= '0;
      r_drop <= '0;
    end else begin
      if (rx_parity_err) begin
        r_err <= sat_inc(r_err);
      end
      if (w_drop) begin
        r_drop <= sat_inc(r_drop);
      end
    end
  end

  // Sticky overrun: a byte arrived while a frame was held
  always_ff @(posedge clk) begin
    if (reset) begin
      r_overrun <= 1'b0;
    end else if (w_clr_ovr) begin
      r_overrun <= 1'b0;
    end else if (w_set_ovr) begin
      r_overrun <= 1'b1;
    end
  end

  uart_frame_buf #(
    .AW (AW)
  ) u_buf (
    .clk   (clk),
    .reset (reset),
    .we    (w_wr),
    .waddr (r_idx[AW-1:0]),
    .wdata (din),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

endmodule
`default_nettype wire

// File: doc/uart_rx_frame_ctrl.md
Name: uart_rx_frame_ctrl

Overview:
Frame controller that sits directly behind the parity-checking UART receiver. It consumes the receiver's byte strobe, data byte and parity-error pulse, and assembles framed packets of the form SYNC, LEN, LEN payload bytes, CHK. Good payloads are held in an internal buffer for the host to read. Frames with a parity error, a bad length, a bad checksum or an inter-byte timeout are discarded and counted.

Parameters:
SYNC_BYTE, 8'hA5, frame start marker
MAX_LEN, 16, maximum payload length (1..MAX_LEN legal)
AW, 4, payload buffer address width (2**AW >= MAX_LEN)
TIMEOUT_TICKS, 4096, s_tick count without a byte before an in-progress frame is aborted

Ports:
clk  in  1  system clock; single clock domain
reset  in  1  synchronous, active-high reset
s_tick  in  1  oversampling tick shared with the receiver
rx_done_tick  in  1  one-cycle byte-received strobe from the receiver
rx_parity_err  in  1  one-cycle parity-mismatch pulse from the receiver; arrives about 16 s_ticks before rx_done_tick
din  in  8  received byte, valid when rx_done_tick=1
frame_ack  in  1  host has consumed the frame
rd_addr  in  AW  payload read index
rd_data  out  8  payload byte at rd_addr (registered, 1-cycle read latency)
frame_valid  out  1  a complete, checked frame is held
frame_len  out  5  payload length of the held frame
overrun  out  1  sticky; a byte arrived while a frame was held
err_cnt  out  8  saturating count of parity errors seen
drop_cnt  out  8  saturating count of discarded frames
busy  out  1  high in any state except HUNT

Behaviour:
- Reset values:
  - state=HUNT
  - all outputs 0, rd_data=0
  - sticky parity flag 0, timeout counter 0, running XOR 0
- Parity flag (perr_q):
  - Set on rx_parity_err.
  - Consumed and cleared on the next rx_done_tick.
  - A byte is bad if perr_q | rx_parity_err is true in its rx_done_tick cycle.
  - Every parity pulse increments err_cnt, saturating at 255.
- States and transitions. All actions happen on rx_done_tick unless noted.
  - HUNT: a good byte equal to SYNC_BYTE goes to LEN. Any other byte stays in HUNT and is not counted as a drop.
  - LEN:
    - Bad byte, din=0, or din>MAX_LEN: drop, go to HUNT.
    - Otherwise latch len=din[4:0], set xor=din, idx=0, go to PAY.
  - PAY:
    - Bad byte: drop, go to HUNT.
    - Otherwise write buf[idx]=din, xor^=din, idx+=1.
    - When idx reaches len-1 on a write, go to CHK.
  - CHK:
    - Good byte with din==xor: go to HOLD. frame_valid and frame_len become valid the cycle after the strobe.
    - Otherwise: drop, go to HUNT.
  - HOLD:
    - frame_valid=1; buffer is frozen.
    - Incoming bytes are ignored and set overrun.
    - frame_ack goes to HUNT, clears frame_valid and overrun next cycle.
    - frame_ack is ignored in all other states.
- "Drop" means drop_cnt+1 (saturating at 255) and the buffer contents are don't-care.
- Timeout:
  - The counter runs only in LEN, PAY and CHK. It increments on s_tick and clears on every rx_done_tick and on state entry.
  - When it reaches TIMEOUT_TICKS: drop, go to HUNT.
  - If rx_done_tick and the terminal s_tick land in the same cycle, the byte wins: the counter clears and the byte is processed.
- rd_data reads the buffer in every state. Contents are guaranteed only while frame_valid=1.
- Reset mid-frame returns to HUNT, clears the counters, and does not count a drop.
- Arithmetic widths: idx is AW+1 bits; the timeout counter is clog2(TIMEOUT_TICKS+1) bits; counters never wrap.

Decomposition:
- Shared package uart_pkg holds:
  - state localparams: HUNT, LEN, PAY, CHK, HOLD
  - the SYNC_BYTE default
  - the counter width constant
- One natural sub-module: uart_frame_buf, a 2**AW x 8 synchronous-write, registered-read RAM.
- The FSM, timeout counter and statistics counters stay in the top module.

Test Plan:
1. Send A5 03 11 22 33 03, all parity good -> frame_valid=1 one cycle after the last strobe. frame_len=3. rd_addr 0/1/2 gives 11/22/33. drop_cnt=0. After frame_ack: frame_valid=0 and busy=0.
2. Same frame with CHK=04 -> no frame_valid. drop_cnt=1. Next A5 03 11 22 33 03 is accepted normally.
3. Same frame with a parity pulse before payload byte 22 -> err_cnt=1, drop_cnt=1, state HUNT. The following bytes 33 03 are ignored.
4. Send A5 00, then A5 11 (17 > MAX_LEN) -> drop_cnt=2. No frame_valid at any point.
5. Send A5 02 AA, then 4096 s_ticks with no strobe -> drop_cnt=1 and busy=0. Repeat with a strobe coincident with tick 4096 -> frame continues.
6. While holding a valid frame, send byte 55 -> overrun=1 and payload unchanged. frame_ack clears both. Then 300 parity pulses -> err_cnt holds at 255.
